fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the pipelined RISC-V core. The block owns the program counter and drives a request/ready handshake to instruction memory. It applies branch and jump redirects, and absorbs decode stalls through a one-entry hold buffer. It presents a valid-qualified instruction whose opcode field feeds the decode-stage control unit directly.

## Interface
Parameters:
- PC_W, 64, program counter and memory address width
- INSTR_W, 32, instruction width
- RESET_PC, 0, PC value after reset

Ports:
- clk  in  1  core clock; all state changes on rising edge
- arst_n  in  1  active-low reset, sampled synchronously on clk (no asynchronous path)
- enable  in  1  start fetching; only consulted in IDLE
- stall_id  in  1  decode cannot accept; hold IF/ID
- branch_taken  in  1  redirect to branch_target
- branch_target  in  PC_W  branch destination
- jump  in  1  redirect to jump_target
- jump_target  in  PC_W  jump destination
- imem_req  out  1  fetch request
- imem_addr  out  PC_W  fetch address (current PC)
- imem_ready  in  1  same-cycle completion; imem_rdata valid when high
- imem_rdata  in  INSTR_W  fetched instruction
- if_id_valid  out  1  IF/ID holds a real instruction
- if_id_pc  out  PC_W  PC of IF/ID instruction
- if_id_instr  out  INSTR_W  IF/ID instruction (NOP 32'h00000013 when invalid)
- if_id_opcode  out  7  if_id_instr[6:0], combinational, to control unit

## Operation
- Reset values: pc=RESET_PC, state=IDLE, imem_req=0, if_id_valid=0, if_id_pc=0, if_id_instr=NOP, hold buffer empty.
- States:
  - IDLE: req=0; enable=1 -> FETCH.
  - FETCH: req=1, addr=pc.
  - KILL: req=1, addr unchanged; wrong-path fetch draining.
  - HOLD: req=0; fetched instruction parked in hold buffer.
- Handshake: once imem_req is high, imem_addr stays stable until a cycle with imem_ready=1. The request never drops before ready.
- redirect = branch_taken | jump; target = branch_taken ? branch_target : jump_target. Branch wins if both are high. target[1:0] is forced to 2'b00.
- FETCH, ready=1, no redirect:
  - IF/ID free (valid=0 or stall_id=0): IF/ID <= {1, pc, rdata}; pc <= pc+4; stay FETCH.
  - Otherwise: buffer <= {pc, rdata}; pc <= pc+4; -> HOLD.
- FETCH, ready=0, no stall: IF/ID valid drops to 0 (bubble). If stall_id=1, IF/ID holds.
- HOLD, stall_id=0: IF/ID <= buffer; -> FETCH.
- Redirect, any state except IDLE: if_id_valid <= 0, if_id_instr <= NOP, buffer discarded, pc <= target.
  - FETCH with ready=0: -> KILL.
  - Otherwise: -> FETCH.
- Redirect has priority over stall.
- KILL: on ready=1, discard rdata; -> FETCH at the redirected pc. A second redirect while in KILL overwrites pc only.
- pc+4 wraps modulo 2^PC_W.
- Reset mid-handshake: all state returns to reset values next edge. The memory must tolerate the request being abandoned.

## Timing
- Zero-wait memory (ready tied high): one instruction per cycle. First if_id_valid=1 two cycles after enable rises in IDLE.
- Fetch-to-IF/ID latency is 1 cycle after the ready cycle.
- Redirect asserted in cycle N: IF/ID invalid from N+1; imem_addr=target from N+1 (or after KILL drains).
- Stall release from HOLD: buffered instruction appears in IF/ID the next cycle; new request starts the same cycle.
- if_id_opcode is purely combinational from the IF/ID register. No path from imem_rdata to any output.

## Structure
- Shared package (fetch_pkg):
  - NOP_INSTR constant.
  - State enum {IDLE, FETCH, KILL, HOLD}.
  - RISC-V opcode constants, also used by decode.
- One natural sub-module: if_hold_buf, a one-entry {pc, instr} register with load/clear.
- Next-PC mux and FSM stay in the top.

## Test plan
- Reset, ready=1, enable=1 at cycle 2, rdata=32'h00500093: imem_addr 0,4,8 on consecutive cycles; if_id_valid=1, if_id_pc=0, if_id_opcode=7'b0010011 at cycle 4.
- ready low for 3 cycles at addr 8: imem_addr held at 8; if_id_valid=0 bubbles; the instruction at 8 enters IF/ID the cycle after ready.
- stall_id=1 with IF/ID valid while the fetch at 12 completes: HOLD, req=0, IF/ID unchanged. Stall release: IF/ID pc=12 next cycle, fetch resumes at 16.
- branch_taken=1, target=0x40, during pending fetch at 20 (ready=0): KILL holds addr 20; on ready, rdata discarded; next addr 0x40; IF/ID invalid throughout.
- branch_taken and jump in the same cycle (targets 0x80/0xC0), also while in HOLD: pc=0x80, buffer discarded, if_id_valid=0.
- Reset asserted mid-KILL: next cycle imem_req=0, pc=RESET_PC, if_id_instr=32'h00000013.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch/decode constants, state encoding and opcode map
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_KILL  = 2'd2,
    ST_HOLD  = 2'd3
  } fetch_state_e;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  function automatic logic [6:0] opcode_of(input logic [31:0] instr);
    return instr[6:0];
  endfunction

endpackage

// File: rtl/if_hold_buf.sv
// rtl/if_hold_buf.sv - one-entry {pc, instr} park register used while decode stalls
module if_hold_buf #(
  parameter int PC_W    = 64,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic               load,
  input  logic               clear,
  input  logic [PC_W-1:0]    pc_in,
  input  logic [INSTR_W-1:0] instr_in,
  output logic               valid,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] instr
);

  logic               valid_q, valid_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;

  // clear wins so a redirect in the same cycle always empties the entry
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      pc_d    = pc_in;
      instr_d = instr_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign valid = valid_q;
  assign pc    = pc_q;
  assign instr = instr_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC, imem request/ready handshake, redirects and IF/ID register
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int              PC_W     = 64,
  parameter int              INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic               enable,
  input  logic               stall_id,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  input  logic               jump,
  input  logic [PC_W-1:0]    jump_target,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_id_valid,
  output logic [PC_W-1:0]    if_id_pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [6:0]         if_id_opcode
);

  localparam logic [INSTR_W-1:0] NOP_W = INSTR_W'(NOP_INSTR);

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    addr_q, addr_d;
  logic               req_q, req_d;
  logic               valid_q, valid_d;
  logic [PC_W-1:0]    ipc_q, ipc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;

  logic               buf_load, buf_clear, buf_valid;
  logic [PC_W-1:0]    buf_pc;
  logic [INSTR_W-1:0] buf_instr;

  logic               redirect;
  logic [PC_W-1:0]    target_raw, target, pc_plus4;

  assign redirect   = branch_taken | jump;
  assign target_raw = branch_taken ? branch_target : jump_target;
  assign target     = {target_raw[PC_W-1:2], 2'b00};
  assign pc_plus4   = pc_q + PC_W'(4);

  if_hold_buf #(.PC_W(PC_W), .INSTR_W(INSTR_W)) u_hold_buf (
    .clk      (clk),
    .arst_n   (arst_n),
    .load     (buf_load),
    .clear    (buf_clear),
    .pc_in    (pc_q),
    .instr_in (imem_rdata),
    .valid    (buf_valid),
    .pc       (buf_pc),
    .instr    (buf_instr)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    valid_d   = valid_q;
    ipc_d     = ipc_q;
    instr_d   = instr_q;
    buf_load  = 1'b0;
    buf_clear = 1'b0;

    if (state_q != ST_IDLE && redirect) begin
      valid_d   = 1'b0;
      instr_d   = NOP_W;
      buf_clear = 1'b1;
      pc_d      = target;
      // an outstanding request must run to ready before the new address goes out
      if ((state_q == ST_FETCH || state_q == ST_KILL) && !imem_ready)
        state_d = ST_KILL;
      else
        state_d = ST_FETCH;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (enable) state_d = ST_FETCH;
        end
        ST_FETCH: begin
          if (imem_ready) begin
            pc_d = pc_plus4;
            if (!valid_q || !stall_id) begin
              valid_d = 1'b1;
              ipc_d   = pc_q;
              instr_d = imem_rdata;
            end else begin
              buf_load = 1'b1;
              state_d  = ST_HOLD;
            end
          end else if (!stall_id) begin
            valid_d = 1'b0;
            instr_d = NOP_W;
          end
        end
        ST_KILL: begin
          if (imem_ready) state_d = ST_FETCH;
        end
        ST_HOLD: begin
          if (!stall_id && buf_valid) begin
            valid_d   = 1'b1;
            ipc_d     = buf_pc;
            instr_d   = buf_instr;
            buf_clear = 1'b1;
            state_d   = ST_FETCH;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    req_d  = (state_d == ST_FETCH) || (state_d == ST_KILL);
    addr_d = (state_d == ST_KILL) ? addr_q : pc_d;
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      ipc_q   <= '0;
      instr_q <= NOP_W;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      ipc_q   <= ipc_d;
      instr_q <= instr_d;
    end
  end

  assign imem_req     = req_q;
  assign imem_addr    = addr_q;
  assign if_id_valid  = valid_q;
  assign if_id_pc     = ipc_q;
  assign if_id_instr  = instr_q;
  assign if_id_opcode = instr_q[6:0];

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized scoreboard bench for fetch_stage
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam int M_IDLE = 0, M_FETCH = 1, M_KILL = 2, M_HOLD = 3;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        enable = 1'b0, stall_id = 1'b0, branch_taken = 1'b0, jump = 1'b0;
  logic [63:0] branch_target = '0, jump_target = '0;
  logic        imem_ready = 1'b0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic [6:0]  if_id_opcode;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [31:0] w;
    w = (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h5A5A_0000;
    return w;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  fetch_stage #(.PC_W(64), .INSTR_W(32), .RESET_PC(64'h0)) dut (
    .clk(clk), .arst_n(arst_n), .enable(enable), .stall_id(stall_id),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
    .if_id_instr(if_id_instr), .if_id_opcode(if_id_opcode)
  );

  typedef struct {
    logic        req;
    logic [63:0] addr;
    logic        valid;
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } slot_t;

  exp_t  sb[$];
  int    total = 0;
  int    bad = 0;

  // reference model: spec-level view of the fetch stage
  int          m_mode;
  logic [63:0] m_pc, m_kill_addr, m_ipc;
  logic        m_v;
  logic [31:0] m_ins;
  slot_t       m_buf[$];

  task automatic model_step();
    logic [63:0] tgt;
    slot_t s;
    if (!arst_n) begin
      m_mode = M_IDLE; m_pc = 64'h0; m_kill_addr = 64'h0;
      m_v = 1'b0; m_ipc = 64'h0; m_ins = NOP; m_buf.delete();
    end else if (m_mode == M_IDLE) begin
      if (enable) m_mode = M_FETCH;
    end else if (branch_taken || jump) begin
      tgt = branch_taken ? branch_target : jump_target;
      tgt[1:0] = 2'b00;
      m_v = 1'b0; m_ins = NOP; m_buf.delete();
      if (m_mode == M_FETCH && !imem_ready) begin
        m_kill_addr = m_pc; m_mode = M_KILL;
      end else if (!(m_mode == M_KILL && !imem_ready)) begin
        m_mode = M_FETCH;
      end
      m_pc = tgt;
    end else if (m_mode == M_FETCH) begin
      if (imem_ready) begin
        if (!m_v || !stall_id) begin
          m_v = 1'b1; m_ipc = m_pc; m_ins = mem_word(m_pc);
        end else begin
          s.pc = m_pc; s.instr = mem_word(m_pc);
          m_buf.push_back(s); m_mode = M_HOLD;
        end
        m_pc = m_pc + 64'd4;
      end else if (!stall_id) begin
        m_v = 1'b0; m_ins = NOP;
      end
    end else if (m_mode == M_KILL) begin
      if (imem_ready) m_mode = M_FETCH;
    end else if (m_mode == M_HOLD) begin
      if (!stall_id) begin
        s = m_buf.pop_front();
        m_v = 1'b1; m_ipc = s.pc; m_ins = s.instr; m_mode = M_FETCH;
      end
    end
  endtask

  task automatic drive(input logic rst_n, input logic en, input logic st,
                       input logic bt, input logic [63:0] bta,
                       input logic j, input logic [63:0] ja, input logic rdy);
    exp_t e;
    @(negedge clk);
    arst_n = rst_n; enable = en; stall_id = st;
    branch_taken = bt; branch_target = bta; jump = j; jump_target = ja;
    imem_ready = rdy;
    model_step();
    e.req   = (m_mode == M_FETCH) || (m_mode == M_KILL);
    e.addr  = (m_mode == M_KILL) ? m_kill_addr : m_pc;
    e.valid = m_v;
    e.pc    = m_ipc;
    e.instr = m_ins;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, req);
    end
  endtask

  // monitor: one expectation per cycle, sampled just after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("imem_req", 64'(imem_req), 64'(e.req));
        chk("imem_addr", imem_addr, e.addr);
        chk("if_id_valid", 64'(if_id_valid), 64'(e.valid));
        if (e.valid) chk("if_id_pc", if_id_pc, e.pc);
        chk("if_id_instr", 64'(if_id_instr), 64'(e.instr));
        chk("if_id_opcode", 64'(if_id_opcode), 64'(e.instr[6:0]));
      end
    end
  end

  function automatic logic [63:0] rand_tgt();
    logic [63:0] t;
    if ($urandom_range(0, 9) == 0) t = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
    else t = 64'($urandom_range(0, 4095));
    return t;
  endfunction

  initial begin
    logic st, bt, j, rdy, rst;
    int rdy_pct, st_pct;
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    // enable, zero-wait stream, wait states at 8, stall, branch during pending fetch
    drive(1, 1, 0, 0, 0, 0, 0, 1);
    drive(1, 1, 0, 0, 0, 0, 0, 1);
    drive(1, 1, 0, 0, 0, 0, 0, 1);
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 0, 1);
    drive(1, 1, 1, 0, 0, 0, 0, 1);
    drive(1, 1, 1, 0, 0, 0, 0, 1);
    drive(1, 1, 0, 0, 0, 0, 0, 1);
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 1, 64'h40, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 0, 1);
    drive(1, 1, 0, 0, 0, 0, 0, 1);
    // both redirects together, once while fetching and once while parked in HOLD
    drive(1, 1, 0, 1, 64'h80, 1, 64'hC0, 1);
    drive(1, 1, 1, 0, 0, 0, 0, 1);
    drive(1, 1, 1, 0, 0, 0, 0, 1);
    drive(1, 1, 1, 1, 64'h81, 1, 64'hC0, 1);
    drive(1, 1, 0, 0, 0, 0, 0, 1);
    // wrap-around of pc+4
    drive(1, 1, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFB, 1);
    repeat (4) drive(1, 1, 0, 0, 0, 0, 0, 1);

    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) begin
        rdy_pct = $urandom_range(30, 100);
        st_pct  = $urandom_range(0, 60);
      end
      rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      st  = ($urandom_range(0, 99) < st_pct);
      rdy = ($urandom_range(0, 99) < rdy_pct);
      bt  = ($urandom_range(0, 99) < 7);
      j   = ($urandom_range(0, 99) < 7);
      drive(rst, ($urandom_range(0, 3) != 0), st, bt, rand_tgt(), j, rand_tgt(), rdy);
    end

    // reset while draining a killed fetch
    drive(1, 1, 0, 0, 0, 0, 0, 1);
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 1, 64'h200, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    drive(1, 1, 0, 0, 0, 0, 0, 1);
    drive(1, 1, 0, 0, 0, 0, 0, 1);
    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
